fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage of the MIPS processor. Sits directly upstream of the main control decoder.
- Holds the PC and runs a request/ready handshake with instruction memory. Latches the fetched word into an instruction register.
- Presents opcode and instruction fields to control and datapath.
- Computes the next PC from the Branch/Jump outputs of the control decoder and the ALU zero flag.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset; must be word-aligned.
- IMEM_TIMEOUT, 8, maximum FETCH cycles without imem_ready before fetch_err is raised; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  instruction memory read request.
- imem_addr  output  32  word-aligned fetch address; equals pc.
- imem_ready  input  1  memory has valid data on imem_rdata this cycle.
- imem_rdata  input  32  fetched instruction word.
- branch  input  1  Branch from control decoder.
- branch_ne  input  1  1 = bne semantics (decoded from ALUOp 4'b0101).
- zero  input  1  ALU zero flag.
- jump  input  1  Jump from control decoder (j / jal).
- jr  input  1  jump-register (R-type funct decode).
- jr_target  input  32  rs value for jr.
- stall  input  1  hold the current instruction in EXEC.
- instr  output  32  instruction register.
- opcode  output  6  instr[31:26], feeds control decoder.
- instr_valid  output  1  instr is live; datapath must gate RegWrite/MemWrite with it.
- pc  output  32  address of the current instruction.
- pc_plus4  output  32  pc + 4, used as the jal link value.
- fetch_err  output  1  sticky: imem timeout occurred.

Behaviour:
- Reset values (asynchronous, rst_n=0): pc=RESET_PC, instr=32'h0, instr_valid=0, imem_req=0, fetch_err=0, state=IDLE, timeout counter=0.
- States: IDLE, FETCH, EXEC.
- IDLE: entered only from reset. Moves to FETCH on the first clock edge after rst_n deasserts.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On an edge with imem_ready=1: instr<=imem_rdata, instr_valid<=1, state<=EXEC, counter cleared.
  - Otherwise the counter increments. On reaching IMEM_TIMEOUT (when nonzero), fetch_err<=1 and the counter saturates; the request stays asserted.
- EXEC:
  - imem_req=0, instr_valid=1.
  - stall=1: hold everything.
  - stall=0: pc<=next_pc, instr_valid<=0, state<=FETCH.
- Minimum 2 cycles per instruction. imem_ready seen outside FETCH is ignored.
- next_pc priority, evaluated combinationally in EXEC:
  1. jr: {jr_target[31:2],2'b00}.
  2. jump: {pc_plus4[31:28], instr[25:0], 2'b00}.
  3. taken branch, where taken = branch & (zero ^ branch_ne): pc_plus4 + (sign-extended instr[15:0] << 2).
  4. otherwise pc_plus4.
- Arithmetic: all 32-bit, wraps modulo 2^32 (pc 32'hFFFF_FFFC + 4 -> 0). No overflow flag.
- opcode is always instr[31:26]; it is only meaningful when instr_valid=1.
- Simultaneous jump and branch: jump wins. jr with any other signal: jr wins.
- Reset mid-FETCH: request drops immediately (asynchronous) and no data is latched. The memory side must tolerate an abandoned request.
- fetch_err clears only on reset.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined: adds output align_err (1 bit, sticky, reset 0). When a jr is taken with jr_target[1:0]!=2'b00, align_err<=1 and the PC is still loaded with the low bits cleared.
- Undefined: no port; low bits are silently cleared.

Test Plan:
- Reset and sequential fetch: release rst_n, imem_ready=1 constantly -> imem_req first high 1 cycle after release with addr 0. pc sequence 0,4,8 at 2 cycles per instruction. instr_valid alternates 0/1.
- Memory wait: imem_ready low for 3 FETCH cycles, then high with rdata 32'h2008_0005 -> instr latched on the 4th FETCH cycle, opcode=6'b001000, fetch_err stays 0.
- Branches:
  - beq at pc 0x10, imm 16'hFFFF, branch=1, zero=1 -> next pc 0x10.
  - Same with branch_ne=1 -> next pc 0x14.
- Jumps:
  - j at pc 0x100, instr[25:0]=26'h40 -> next pc 0x100.
  - jr=1, jump=1, branch=1, jr_target 0x2000 -> next pc 0x2000.
- Stall and reset:
  - stall=1 for 3 EXEC cycles -> pc, instr and instr_valid held, imem_req=0.
  - rst_n pulsed low mid-FETCH at pc 0x40 -> imem_req=0 immediately, pc=RESET_PC.
- Timeout: IMEM_TIMEOUT=8, imem_ready held low 10 cycles -> fetch_err=1 from the 9th FETCH cycle. Stays 1 after ready returns.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem request/ready handshake, instruction register, next-PC select.
// Optional FETCH_ALIGN_CHECK_EN adds a sticky align_err output for misaligned jr targets.
module fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        branch,
  input  logic        branch_ne,
  input  logic        zero,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        align_err
`endif
);

  localparam int unsigned CNT_W = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic [31:0]      next_pc;
  logic [31:0]      br_off;
  logic             taken;

  assign imem_addr = pc;
  assign opcode    = instr[31:26];
  assign pc_plus4  = pc + 32'd4;

`ifndef FETCH_ALIGN_CHECK_EN
  // Low target bits are dropped without reporting in this build.
  logic unused_jr_lsbs;
  assign unused_jr_lsbs = ^jr_target[1:0];
`endif

  // Next-PC select: jr > jump > taken branch > sequential.
  always_comb begin
    taken   = branch & (zero ^ branch_ne);
    br_off  = {{14{instr[15]}}, instr[15:0], 2'b00};
    next_pc = pc_plus4;
    if (jr) begin
      next_pc = {jr_target[31:2], 2'b00};
    end else if (jump) begin
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (taken) begin
      next_pc = pc_plus4 + br_off;
    end
  end

  // Fetch FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      fetch_err   <= 1'b0;
      tmo_cnt     <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      align_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            tmo_cnt     <= '0;
            state       <= EXEC;
          end else if ((IMEM_TIMEOUT != 0) && (tmo_cnt != CNT_W'(IMEM_TIMEOUT))) begin
            // Counter saturates at the limit; the request stays up.
            tmo_cnt <= tmo_cnt + CNT_W'(1);
            if (tmo_cnt == CNT_W'(IMEM_TIMEOUT - 1)) begin
              fetch_err <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (!stall) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= FETCH;
`ifdef FETCH_ALIGN_CHECK_EN
            if (jr && (jr_target[1:0] != 2'b00)) begin
              align_err <= 1'b1;
            end
`endif
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (default parameters).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        branch;
  logic        branch_ne;
  logic        zero;
  logic        jump;
  logic        jr;
  logic [31:0] jr_target;
  logic        stall;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        align_err;
`endif

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .branch      (branch),
    .branch_ne   (branch_ne),
    .zero        (zero),
    .jump        (jump),
    .jr          (jr),
    .jr_target   (jr_target),
    .stall       (stall),
    .instr       (instr),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_err   (fetch_err)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .align_err   (align_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in FETCH: present one word, land in EXEC at the next negedge.
  task automatic do_fetch(input logic [31:0] word);
    imem_ready = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ready = 1'b0;
  endtask

  task automatic clear_ctrl();
    branch    = 1'b0;
    branch_ne = 1'b0;
    zero      = 1'b0;
    jump      = 1'b0;
    jr        = 1'b0;
    jr_target = 32'h0;
  endtask

  initial begin
    rst_n      = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    stall      = 1'b0;
    clear_ctrl();
    repeat (2) @(negedge clk);

    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_err", 32'(fetch_err), 32'h0);

    // Release: request appears one cycle later at address 0.
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_req", 32'(imem_req), 32'h1);
    chk("first_addr", imem_addr, 32'h0);

    // Sequential fetch with memory always ready.
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("seq_pc", pc, 32'(4 * i));
      chk("seq_valid_fetch", 32'(instr_valid), 32'h0);
      imem_rdata = 32'hAC00_0000 + 32'(i);
      @(negedge clk);
      chk("seq_valid_exec", 32'(instr_valid), 32'h1);
      chk("seq_req_exec", 32'(imem_req), 32'h0);
      chk("seq_instr", instr, 32'hAC00_0000 + 32'(i));
      @(negedge clk);
    end
    chk("seq_pc_end", pc, 32'hC);

    // Memory wait of three cycles.
    imem_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("wait_req", 32'(imem_req), 32'h1);
      chk("wait_valid", 32'(instr_valid), 32'h0);
    end
    do_fetch(32'h2008_0005);
    chk("wait_instr", instr, 32'h2008_0005);
    chk("wait_opcode", 32'(opcode), 32'h8);
    chk("wait_valid_exec", 32'(instr_valid), 32'h1);
    chk("wait_err", 32'(fetch_err), 32'h0);
    @(negedge clk);
    chk("pc_0x10", pc, 32'h10);

    // beq backwards by one word: lands on itself.
    do_fetch(32'h1000_FFFF);
    branch = 1'b1; zero = 1'b1;
    @(negedge clk);
    clear_ctrl();
    chk("beq_taken", pc, 32'h10);

    // bne with zero=1: not taken.
    do_fetch(32'h1000_FFFF);
    branch = 1'b1; zero = 1'b1; branch_ne = 1'b1;
    @(negedge clk);
    clear_ctrl();
    chk("bne_not_taken", pc, 32'h14);

    // j to 0x100, twice.
    do_fetch(32'h0800_0040);
    jump = 1'b1;
    @(negedge clk);
    clear_ctrl();
    chk("j_first", pc, 32'h100);
    do_fetch(32'h0800_0040);
    jump = 1'b1;
    @(negedge clk);
    clear_ctrl();
    chk("j_self", pc, 32'h100);

    // jr beats jump and branch.
    do_fetch(32'h1000_0040);
    jr = 1'b1; jump = 1'b1; branch = 1'b1; zero = 1'b1; jr_target = 32'h2000;
    @(negedge clk);
    clear_ctrl();
    chk("jr_priority", pc, 32'h2000);

    // Misaligned jr target: low bits cleared.
    do_fetch(32'h0000_0008);
    jr = 1'b1; jr_target = 32'h2006;
    @(negedge clk);
    clear_ctrl();
    chk("jr_align", pc, 32'h2004);

    // bne taken forward by 3 words.
    do_fetch(32'h1000_0003);
    branch = 1'b1; branch_ne = 1'b1;
    @(negedge clk);
    clear_ctrl();
    chk("bne_fwd", pc, 32'h2014);
    chk("pc_plus4", pc_plus4, 32'h2018);

    // Stall in EXEC; ready/data during EXEC must be ignored.
    do_fetch(32'h2008_0005);
    stall = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    repeat (3) begin
      @(negedge clk);
      chk("stall_pc", pc, 32'h2014);
      chk("stall_instr", instr, 32'h2008_0005);
      chk("stall_valid", 32'(instr_valid), 32'h1);
      chk("stall_req", 32'(imem_req), 32'h0);
    end
    stall = 1'b0;
    imem_ready = 1'b0;
    @(negedge clk);
    chk("unstall_pc", pc, 32'h2018);
    chk("unstall_valid", 32'(instr_valid), 32'h0);

    // Jump to 0x40 then reset in the middle of FETCH.
    do_fetch(32'h0800_0010);
    jump = 1'b1;
    @(negedge clk);
    clear_ctrl();
    chk("pc_0x40", pc, 32'h40);
    chk("req_0x40", 32'(imem_req), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(imem_req), 32'h0);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_valid", 32'(instr_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rerst_req", 32'(imem_req), 32'h1);
    chk("rerst_pc", pc, 32'h0);
    chk("rerst_err", 32'(fetch_err), 32'h0);

    // Timeout: ready low for 10 FETCH cycles; error from the 9th cycle.
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("tmo_err", 32'(fetch_err), (k >= 8) ? 32'h1 : 32'h0);
      chk("tmo_req", 32'(imem_req), 32'h1);
    end
    do_fetch(32'h0000_0020);
    chk("tmo_valid", 32'(instr_valid), 32'h1);
    chk("tmo_err_sticky", 32'(fetch_err), 32'h1);
    @(negedge clk);
    chk("tmo_pc", pc, 32'h4);
    chk("tmo_err_sticky2", 32'(fetch_err), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
